// File: rtl/ula_seq_if.sv
// Command/result bundle for the sequential ALU: request fields, status flags,
// and the debug register-file read port.
interface ula_seq_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              start;
  logic [3:0]        codop;
  logic [REG_AW-1:0] s4;
  logic [REG_AW-1:0] s3;
  logic [REG_AW-1:0] s2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;
  logic              ovf;
  logic              err;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output start, codop, s4, s3, s2, dbg_addr,
    input  busy, done, result, zero, carry, ovf, err, dbg_data
  );

  modport slave (
    input  start, codop, s4, s3, s2, dbg_addr,
    output busy, done, result, zero, carry, ovf, err, dbg_data
  );
endinterface

// File: rtl/ula_seq.sv
// Four-state sequential ALU (IDLE/READ/EXEC/WB) over a 2**REG_AW register file
// with R0 hardwired to zero; one operation every four cycles.
module ula_seq #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic       CLK_50,
  input  logic       RST,
  ula_seq_if.slave   bus
);
  localparam int DEPTH = 2 ** REG_AW;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [3:0]        codop_q, codop_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic              zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic              err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic              wr_en;
  logic [DATA_W-1:0] rf_q [DEPTH];

  logic [DATA_W-1:0] imm, op_x, op_y, alu_res;
  logic [DATA_W:0]   sum_w, dif_w;
  logic              alu_c, alu_v, alu_err;

  // Immediate forms (codop[3]=1) run B against IMM; register forms run A against B.
  // NOTE: combinational blocks use blocking '=' so later lines see values computed earlier.
  always_comb begin
    imm     = DATA_W'(rs_q);
    op_x    = codop_q[3] ? b_q : a_q;
    op_y    = codop_q[3] ? imm : b_q;
    sum_w   = {1'b0, op_x} + {1'b0, op_y};
    dif_w   = {1'b0, op_x} - {1'b0, op_y};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (codop_q)
      4'b0000, 4'b1001: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (op_x[DATA_W-1] == op_y[DATA_W-1]) && (alu_res[DATA_W-1] != op_x[DATA_W-1]);
      end
      4'b0001, 4'b1010: begin
        alu_res = dif_w[DATA_W-1:0];
        alu_c   = dif_w[DATA_W];
        alu_v   = (op_x[DATA_W-1] != op_y[DATA_W-1]) && (alu_res[DATA_W-1] != op_x[DATA_W-1]);
      end
      4'b0010: alu_res = DATA_W'(a_q < b_q);
      4'b0011: alu_res = a_q & b_q;
      4'b0100: alu_res = a_q | b_q;
      4'b0101: alu_res = a_q ^ b_q;
      4'b0110: alu_res = b_q & imm;
      4'b0111: alu_res = b_q | imm;
      4'b1000: alu_res = b_q ^ imm;
      default: alu_err = 1'b1;
    endcase
  end

  // NOTE: every signal gets its hold/default value first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    codop_d  = codop_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          codop_d = bus.codop;
          rd_d    = bus.s4;
          rs_d    = bus.s3;
          rt_d    = bus.s2;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        a_d     = rf_q[rs_q];
        b_d     = rf_q[rt_q];
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_c;
        ovf_d    = alu_v;
        err_d    = alu_err;
        state_d  = WB;
      end
      WB: begin
        wr_en   = !err_q && (rd_q != '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the register file is reset along with the control state, so reset must clear every entry.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q  <= IDLE;
      codop_q  <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      codop_q  <= codop_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (wr_en) rf_q[rd_q] <= result_q;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : rf_q[bus.dbg_addr];
endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter DATA_W, default 16, datapath, register and result width (min 4).
REQ-002 Parameter REG_AW, default 4, register-address width; register file depth 2**REG_AW.
REQ-003 CLK_50  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 codop  in  4  operation code.
REQ-007 s4  in  REG_AW  destination register address (rd).
REQ-008 s3  in  REG_AW  source A address (rs); also the immediate for immediate ops.
REQ-009 s2  in  REG_AW  source B address (rt).
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 result  out  DATA_W  last computed value.
REQ-013 zero, carry, ovf  out  1 each  flags of the last operation.
REQ-014 err  out  1  last operation used an illegal codop.
REQ-015 dbg_addr  in  REG_AW / dbg_data  out  DATA_W  combinational register-file read port.

Function
REQ-016 FSM states: IDLE, READ, EXEC, WB; all outputs registered except dbg_data.
REQ-017 IDLE with start=1 at an edge: latch codop, s4, s3, s2; go to READ; busy=1.
REQ-018 READ: A=R[rs], B=R[rt], IMM=zero-extended rs field; go to EXEC.
REQ-019 EXEC: result and flags registered; go to WB.
REQ-020 WB: write result to R[rd]; done=1, busy=0 for exactly this cycle; go to IDLE.
REQ-021 Latency: done high in the cycle after the 3rd edge following the accepting edge; next start accepted at the following edge (4-cycle throughput).
REQ-022 start asserted outside IDLE is ignored; no queuing.
REQ-023 Ops: 0000 A+B; 0001 A-B; 0010 (A<B unsigned)?1:0; 0011 A&B; 0100 A|B; 0101 A^B; 0110 B&IMM; 0111 B|IMM; 1000 B^IMM; 1001 B+IMM; 1010 B-IMM.
REQ-024 All arithmetic is modulo 2**DATA_W.
REQ-025 carry: add = carry-out of bit DATA_W-1; sub = borrow (minuend < subtrahend unsigned); 0 for other ops.
REQ-026 ovf: signed two's-complement overflow for add/sub; 0 for other ops.
REQ-027 zero=1 iff result==0, all ops.
REQ-028 codop 1011..1111: result=0, zero=1, carry=ovf=0, err=1, no register write; done still pulses.
REQ-029 err=0 on every legal op; flags and err hold until the next EXEC.
REQ-030 R[0] is hardwired to 0; writes to rd=0 are discarded; dbg_data for address 0 reads 0.
REQ-031 Operand read for an op accepted right after WB sees the value written in that WB; no forwarding required.

Reset
REQ-032 RST=1 at an edge: state IDLE; busy=done=err=0; result=0; zero=carry=ovf=0; all registers 0.
REQ-033 RST overrides start and any in-flight state; an interrupted op performs no write and produces no done.

Verification
REQ-034 RST 1 cycle -> busy=done=0, result=0, dbg_data=0 for all addresses.
REQ-035 codop 1001 rd=1 rs=5 rt=0; codop 1001 rd=2 rs=3 rt=0; codop 0000 rd=3 rs=1 rt=2 -> result=8, zero=0, dbg R3=8, each done exactly 3 edges after accept.
REQ-036 Then codop 0001 rd=4 rs=2 rt=1 -> R4=0xFFFE, carry=1, zero=0; codop 0001 rd=5 rs=1 rt=1 -> result 0, zero=1, carry=0; codop 0010 rd=6 rs=2 rt=1 -> R6=1.
REQ-037 codop 0000 rd=0 rs=1 rt=2 -> result=8, dbg R0=0; codop 1100 rd=7 -> err=1, result=0, R7 unchanged 0.
REQ-038 start held high through an op -> only one done per 4 cycles; RST pulsed in EXEC of codop 1001 rd=9 rs=7 -> no done, R9=0, busy=0 next cycle.
REQ-039 DATA_W=8 instance: build R1=0x7F via immediates, codop 0000 R1+R1 -> result 0xFE, ovf=1, carry=0.
